// File: rtl/btn_pkg.sv
// btn_pkg: shared channel state encodings and counter sizing helper
package btn_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2} btn_state_e;
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button channel with sync, debounce, hold FSM and pulses
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int ACTIVE_LOW  = 0,
   parameter int DEB_CYCLES  = 1000000,
   parameter int LONG_CYCLES = 50000000,
   parameter int REP_CYCLES  = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic rel_pulse,
   output logic long_pulse,
   output logic rep_pulse
);
   localparam int DW = cnt_w(DEB_CYCLES);
   localparam int HW = cnt_w(LONG_CYCLES > REP_CYCLES ? LONG_CYCLES : REP_CYCLES);
   logic s1, s2, s, toggle, rise, fall, long_nxt, rep_nxt;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   btn_state_e state, state_nxt;
   assign s      = (ACTIVE_LOW != 0) ? ~s2 : s2;
   assign toggle = (s != level) && (deb_cnt == DW'(DEB_CYCLES - 1));
   assign rise   = toggle && !level;
   assign fall   = toggle && level;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         deb_cnt     <= '0;
         level       <= 1'b0;
         press_pulse <= 1'b0;
         rel_pulse   <= 1'b0;
         long_pulse  <= 1'b0;
         rep_pulse   <= 1'b0;
         hold_cnt    <= '0;
         state       <= IDLE;
      end else begin
         s1          <= btn;
         s2          <= s1;
         deb_cnt     <= (s == level || toggle) ? '0 : deb_cnt + 1'b1;
         level       <= level ^ toggle;
         press_pulse <= rise;
         rel_pulse   <= fall;
         long_pulse  <= long_nxt;
         rep_pulse   <= rep_nxt;
         hold_cnt    <= hold_nxt;
         state       <= state_nxt;
      end
   end
   // a falling level is checked first so release beats a coincident long/repeat threshold
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      long_nxt  = 1'b0;
      rep_nxt   = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = rise ? HELD : IDLE;
            hold_nxt  = rise ? '0 : hold_cnt;
         end
         HELD: begin
            if (fall) state_nxt = IDLE;
            else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
               hold_nxt  = '0;
            end else hold_nxt = hold_cnt + 1'b1;
         end
         LONG: begin
            if (fall) state_nxt = IDLE;
            else if (REP_CYCLES != 0) begin
               rep_nxt  = (hold_cnt == HW'(REP_CYCLES - 1));
               hold_nxt = rep_nxt ? '0 : hold_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N independent button conditioning channels
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int ACTIVE_LOW  = 0,
   parameter int DEB_CYCLES  = 1000000,
   parameter int LONG_CYCLES = 50000000,
   parameter int REP_CYCLES  = 10000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] rel_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] rep_pulse
);
   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .ACTIVE_LOW (ACTIVE_LOW),
         .DEB_CYCLES (DEB_CYCLES),
         .LONG_CYCLES(LONG_CYCLES),
         .REP_CYCLES (REP_CYCLES)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .btn        (btn[i]),
         .level      (btn_level[i]),
         .press_pulse(press_pulse[i]),
         .rel_pulse  (rel_pulse[i]),
         .long_pulse (long_pulse[i]),
         .rep_pulse  (rep_pulse[i])
      );
   end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed checks of debounce, pulses, long-press and repeat
module tb_btn_debounce_multi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] btn = 4'hF;
   logic [3:0] a_level, a_press, a_rel, a_long, a_rep;
   logic [3:0] b_level, b_press, b_rel, b_long, b_rep;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btn_debounce_multi #(.N_BTN(4), .ACTIVE_LOW(0), .DEB_CYCLES(4), .LONG_CYCLES(20), .REP_CYCLES(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn(btn), .btn_level(a_level), .press_pulse(a_press),
      .rel_pulse(a_rel), .long_pulse(a_long), .rep_pulse(a_rep));

   btn_debounce_multi #(.N_BTN(4), .ACTIVE_LOW(0), .DEB_CYCLES(4), .LONG_CYCLES(20), .REP_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn(btn), .btn_level(b_level), .press_pulse(b_press),
      .rel_pulse(b_rel), .long_pulse(b_long), .rep_pulse(b_rep));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn   = 4'hF;
      repeat (3) begin
         tick();
         checks++;
         if ({a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep} !== 40'h0) begin
            errors++;
            $display("FAIL reset_hold got %h expected 0", {a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep});
         end
      end
      rst_n = 1'b1;
      btn   = 4'h0;
      repeat (8) begin
         tick();
         checks++;
         if ({a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep} !== 40'h0) begin
            errors++;
            $display("FAIL reset_after got %h expected 0", {a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep});
         end
      end
   endtask

   task automatic test_clean_press();
      btn[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if ({a_level[0], a_press[0]} !== {1'(k >= 6), 1'(k == 6)}) begin
            errors++;
            $display("FAIL clean_press k=%0d got lvl=%b press=%b expected lvl=%b press=%b", k, a_level[0], a_press[0], k >= 6, k == 6);
         end
      end
      btn[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if ({a_level[0], a_rel[0]} !== {1'(k < 6), 1'(k == 6)}) begin
            errors++;
            $display("FAIL clean_release k=%0d got lvl=%b rel=%b expected lvl=%b rel=%b", k, a_level[0], a_rel[0], k < 6, k == 6);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_bounce();
      int np = 0;
      int nr = 0;
      for (int j = 0; j < 10; j++) begin
         btn[1] = ((j / 2) % 2) == 0;
         tick();
         np += int'(a_press[1]);
         nr += int'(a_rel[1]);
      end
      btn[1] = 1'b1;
      repeat (20) begin
         tick();
         np += int'(a_press[1]);
         nr += int'(a_rel[1]);
      end
      checks++;
      if (np != 1) begin
         errors++;
         $display("FAIL bounce_press_count got %0d expected 1", np);
      end
      checks++;
      if (nr != 0) begin
         errors++;
         $display("FAIL bounce_rel_count got %0d expected 0", nr);
      end
      checks++;
      if (a_level[1] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_level got %b expected 1", a_level[1]);
      end
      btn[1] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_long_repeat();
      btn[2] = 1'b1;
      repeat (6) tick();
      checks++;
      if (a_press[2] !== 1'b1) begin
         errors++;
         $display("FAIL long_press_pulse got %b expected 1", a_press[2]);
      end
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++;
         if ({a_long[2], a_rep[2]} !== {1'(k == 20), 1'(k == 28 || k == 36)}) begin
            errors++;
            $display("FAIL long_repeat k=%0d got long=%b rep=%b expected long=%b rep=%b", k, a_long[2], a_rep[2], k == 20, k == 28 || k == 36);
         end
      end
      btn[2] = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_no_repeat();
      int nl = 0;
      int nrep = 0;
      int nr = 0;
      btn[2] = 1'b1;
      repeat (6) tick();
      checks++;
      if (b_press[2] !== 1'b1) begin
         errors++;
         $display("FAIL norep_press_pulse got %b expected 1", b_press[2]);
      end
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++;
         if ({b_long[2], b_rep[2]} !== {1'(k == 20), 1'b0}) begin
            errors++;
            $display("FAIL norep_hold k=%0d got long=%b rep=%b expected long=%b rep=0", k, b_long[2], b_rep[2], k == 20);
         end
      end
      btn[2] = 1'b0;
      repeat (10) begin
         tick();
         nl += int'(b_long[2]);
         nrep += int'(b_rep[2]);
         nr += int'(b_rel[2]);
      end
      checks++;
      if ({nl, nrep, nr} !== {32'd0, 32'd0, 32'd1}) begin
         errors++;
         $display("FAIL norep_release got long=%0d rep=%0d rel=%0d expected 0 0 1", nl, nrep, nr);
      end
   endtask

   task automatic test_simul_reset();
      btn = 4'b1001;
      repeat (6) tick();
      checks++;
      if ({a_press, a_level, b_press} !== {4'b1001, 4'b1001, 4'b1001}) begin
         errors++;
         $display("FAIL simul_press got a_press=%b a_lvl=%b b_press=%b expected 1001 1001 1001", a_press, a_level, b_press);
      end
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep} !== 40'h0) begin
         errors++;
         $display("FAIL midhold_reset got %h expected 0", {a_level, a_press, a_rel, a_long, a_rep, b_level, b_press, b_rel, b_long, b_rep});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if ({a_press, a_level, b_press} !== {(k == 6) ? 4'b1001 : 4'b0000, (k >= 6) ? 4'b1001 : 4'b0000, (k == 6) ? 4'b1001 : 4'b0000}) begin
            errors++;
            $display("FAIL repress_after_reset k=%0d got a_press=%b a_lvl=%b b_press=%b", k, a_press, a_level, b_press);
         end
      end
      btn = 4'b0000;
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_repeat();
      test_no_repeat();
      test_simul_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
